pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage core. Collects hazard and stall sources:
//   - load-use hazard (ID), EX redirect, multi-cycle EX op (div), LSU bus wait (MEM).
//  Drives hold/scour flags of pc, if_id, id_ex and ex_mem, plus the PC redirect.
//  Tracks multi-cycle ops with an FSM and timeout watchdog; keeps a stall perf counter.
// PARAMETERS
//  MC_TIMEOUT  64  max MC_WAIT cycles before the EX op is killed; 0 disables the watchdog
//  CNT_W       32  width of stall_cnt_o
// PORTS
//  clk            in   1      core clock
//  rst_n          in   1      reset, asynchronous, active-low
//  load_use_i     in   1      ID instruction needs result of load currently in EX
//  jump_flag_i    in   1      EX redirect request (mispredict / jump not predicted)
//  jump_addr_i    in   32     redirect target
//  mc_start_i     in   1      EX starts a multi-cycle op this cycle (pulse)
//  mc_done_i      in   1      multi-cycle result valid this cycle (pulse)
//  mem_stall_i    in   1      LSU bus wait; MEM stage cannot retire
//  perf_clr_i     in   1      synchronous clear of stall_cnt_o
//  pc_hold_flag   out  1      freeze PC
//  id_hold_flag   out  1      freeze if_id;   id_scour_flag out 1  bubble into if_id
//  ex_hold_flag   out  1      freeze id_ex;   ex_scour_flag out 1  bubble into id_ex
//  mem_hold_flag  out  1      freeze ex_mem;  mem_scour_flag out 1 bubble into ex_mem
//  jump_flag_o    out  1      redirect PC this cycle;  jump_addr_o out 32  target
//  mc_timeout_o   out  1      one-cycle pulse: multi-cycle op killed by watchdog
//  stall_cnt_o    out  CNT_W  saturating count of cycles with pc_hold_flag=1
// BEHAVIOUR
//  Reset: state=RUN, wd_cnt=0, stall_cnt_o=0, mc_timeout_o=0. While rst_n=0 all flag outputs,
//   jump_flag_o=0 and jump_addr_o=0.
//  Flags and jump_* are combinational from state+inputs, same-cycle effect (0 latency).
//   jump_addr_o = jump_addr_i whenever jump_flag_o=1, else 0.
//  Hold/scour flags: a scour never coincides with the hold of the same register.
//  FSM states: RUN, MC_WAIT, MC_DONE.
//  Priority (high->low): mem_stall_i > timeout kill > redirect > MC stall > load-use.
//  mem_stall_i=1, any state:
//   - pc/id/ex/mem_hold=1, no scours, jump_flag_o=0. State and wd_cnt frozen,
//     except MC_WAIT+mc_done_i -> MC_DONE.
//   - A redirect is deferred; EX is frozen, so jump_flag_i re-asserts later.
//  RUN, redirect (jump_flag_i=1):
//   - jump_flag_o=1, id_scour=1, ex_scour=1, no holds.
//   - Overrides load_use_i. Any mc_start_i in that cycle is ignored.
//  RUN, mc_start_i=1 and mc_done_i=0:
//   - pc/id/ex_hold=1, mem_scour=1; next state MC_WAIT, wd_cnt<=0.
//   - mc_start_i with mc_done_i in the same cycle: no stall, stay RUN.
//  RUN, load_use_i only: pc_hold=1, id_hold=1, ex_scour=1 (one bubble per cycle asserted).
//  MC_WAIT, mc_done_i=0:
//   - pc/id/ex_hold=1, mem_scour=1; wd_cnt++.
//   - If MC_TIMEOUT!=0 and wd_cnt==MC_TIMEOUT-1: pc/id_hold=1, ex_scour=1, mem_scour=1;
//     next RUN; mc_timeout_o=1 next cycle.
//  MC_WAIT, mc_done_i=1: all flags 0 (result enters ex_mem); next RUN.
//  MC_DONE, mem_stall_i=1: full freeze, stay.
//  MC_DONE, mem_stall_i=0: all flags 0; next RUN.
//  load_use_i and jump_flag_i ignored in MC_WAIT/MC_DONE; jump_flag_i likewise ignored
//   in the watchdog-kill cycle. Both are reconsidered once back in RUN.
//  stall_cnt_o: +1 on each cycle with pc_hold_flag=1, saturates at 2^CNT_W-1.
//   perf_clr_i wins over increment.
//  Async reset mid-MC_WAIT: immediate return to RUN and all outputs to reset values.
// TESTING
//  T1 load_use_i=1 one cycle in RUN -> pc_hold=id_hold=ex_scour=1 that cycle only.
//   Then flags 0, stall_cnt_o=1.
//  T2 jump_flag_i=1, jump_addr_i=0x0000_0100, load_use_i=1 -> jump_flag_o=1, addr 0x100.
//   id_scour=ex_scour=1, pc_hold=0.
//  T3 mc_start_i at t0, mc_done_i at t0+5 -> pc/id/ex_hold=1 and mem_scour=1 t0..t0+4.
//   All 0 at t0+5; stall_cnt_o=5.
//  T4 MC_TIMEOUT=8, mc_start_i, no done -> kill cycle at t0+8 (ex_scour=1).
//   mc_timeout_o=1 at t0+9, state RUN.
//  T5 MC_WAIT, mem_stall_i=1 with mc_done_i -> all four holds=1 while stalled.
//   Release when mem_stall_i=0 with flags 0, then RUN.
//  T6 jump_flag_i with mem_stall_i=1 for 3 cycles -> jump_flag_o=0 during stall.
//   =1 in the first cycle after; rst_n low mid-MC_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : 5-stage pipeline hold/scour sequencer with multi-cycle watchdog
// Revision  : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    input  logic             mem_stall_i,
    input  logic             perf_clr_i,
    output logic             pc_hold_flag,
    output logic             id_hold_flag,
    output logic             id_scour_flag,
    output logic             ex_hold_flag,
    output logic             ex_scour_flag,
    output logic             mem_hold_flag,
    output logic             mem_scour_flag,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int              WD_W    = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);
    localparam bit              WD_EN   = (MC_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [WD_W-1:0] wd_cnt, wd_nx;
    logic            kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wd_cnt       <= '0;
            mc_timeout_o <= 1'b0;
        end else begin
            state        <= state_nx;
            wd_cnt       <= wd_nx;
            mc_timeout_o <= kill;
        end
    end

    always_comb begin
        state_nx       = state;
        wd_nx          = wd_cnt;
        kill           = 1'b0;
        pc_hold_flag   = 1'b0;
        id_hold_flag   = 1'b0;
        id_scour_flag  = 1'b0;
        ex_hold_flag   = 1'b0;
        ex_scour_flag  = 1'b0;
        mem_hold_flag  = 1'b0;
        mem_scour_flag = 1'b0;
        jump_flag_o    = 1'b0;
        if (!rst_n) begin
            state_nx = RUN;
        end else if (mem_stall_i) begin
            // Full freeze; only a result landing during the stall is remembered.
            pc_hold_flag  = 1'b1;
            id_hold_flag  = 1'b1;
            ex_hold_flag  = 1'b1;
            mem_hold_flag = 1'b1;
            if (state == MC_WAIT && mc_done_i)
                state_nx = MC_DONE;
        end else begin
            case (state)
                RUN: begin
                    if (jump_flag_i) begin
                        jump_flag_o   = 1'b1;
                        id_scour_flag = 1'b1;
                        ex_scour_flag = 1'b1;
                    end else if (mc_start_i && !mc_done_i) begin
                        pc_hold_flag   = 1'b1;
                        id_hold_flag   = 1'b1;
                        ex_hold_flag   = 1'b1;
                        mem_scour_flag = 1'b1;
                        state_nx       = MC_WAIT;
                        wd_nx          = '0;
                    end else if (load_use_i) begin
                        pc_hold_flag  = 1'b1;
                        id_hold_flag  = 1'b1;
                        ex_scour_flag = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (mc_done_i) begin
                        state_nx = RUN;
                    end else if (WD_EN && wd_cnt == WD_LAST) begin
                        // Watchdog kill: the stuck EX op is flushed instead of held.
                        pc_hold_flag   = 1'b1;
                        id_hold_flag   = 1'b1;
                        ex_scour_flag  = 1'b1;
                        mem_scour_flag = 1'b1;
                        kill           = 1'b1;
                        state_nx       = RUN;
                    end else begin
                        pc_hold_flag   = 1'b1;
                        id_hold_flag   = 1'b1;
                        ex_hold_flag   = 1'b1;
                        mem_scour_flag = 1'b1;
                        wd_nx          = wd_cnt + WD_W'(1);
                    end
                end
                MC_DONE: state_nx = RUN;
                default: state_nx = RUN;
            endcase
        end
    end

    assign jump_addr_o = jump_flag_o ? jump_addr_i : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_o <= '0;
        else if (perf_clr_i)
            stall_cnt_o <= '0;
        else if (pc_hold_flag && stall_cnt_o != CNT_MAX)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_ctrl : directed + random checks of pipe_ctrl against a flag-level model
// Revision     : 1.0
// ============================================================================
module tb_pipe_ctrl;

    localparam int TO = 8;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_use_i, jump_flag_i, mc_start_i, mc_done_i, mem_stall_i, perf_clr_i;
    logic [31:0]   jump_addr_i;
    logic          pc_hold_flag, id_hold_flag, id_scour_flag, ex_hold_flag, ex_scour_flag;
    logic          mem_hold_flag, mem_scour_flag, jump_flag_o, mc_timeout_o;
    logic [31:0]   jump_addr_o;
    logic [CW-1:0] stall_cnt_o;

    pipe_ctrl #(.MC_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_i(load_use_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .mc_start_i(mc_start_i), .mc_done_i(mc_done_i), .mem_stall_i(mem_stall_i),
        .perf_clr_i(perf_clr_i),
        .pc_hold_flag(pc_hold_flag), .id_hold_flag(id_hold_flag), .id_scour_flag(id_scour_flag),
        .ex_hold_flag(ex_hold_flag), .ex_scour_flag(ex_scour_flag),
        .mem_hold_flag(mem_hold_flag), .mem_scour_flag(mem_scour_flag),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .mc_timeout_o(mc_timeout_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    logic [6:0] dut_fl;
    assign dut_fl = {pc_hold_flag, id_hold_flag, id_scour_flag, ex_hold_flag,
                     ex_scour_flag, mem_hold_flag, mem_scour_flag};

    int total = 0, passes = 0, fails = 0;

    // Model: op in flight, result parked behind a bus stall, cycles waited so far
    bit       m_busy, m_held, m_to, e_jf, e_kill;
    int       m_wait, m_cnt;
    bit [6:0] e_fl;

    logic [6:0]    o_fl;
    logic          o_jf, o_to;
    logic [31:0]   o_ja;
    logic [CW-1:0] o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_held = 0; m_to = 0; m_wait = 0; m_cnt = 0;
    endtask

    task automatic model_outputs();
        e_fl = '0; e_jf = 0; e_kill = 0;
        if (!rst_n) begin
        end else if (mem_stall_i) e_fl = 7'b1101010;
        else if (m_held) begin
        end else if (m_busy) begin
            if (mc_done_i) begin
            end else if (TO != 0 && m_wait == TO - 1) begin
                e_fl = 7'b1100101; e_kill = 1;
            end else e_fl = 7'b1101001;
        end else if (jump_flag_i) begin
            e_jf = 1; e_fl = 7'b0010100;
        end else if (mc_start_i && !mc_done_i) e_fl = 7'b1101001;
        else if (load_use_i) e_fl = 7'b1100100;
    endtask

    task automatic model_advance();
        bit nto;
        nto = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (mem_stall_i) begin
                if (m_busy && mc_done_i) begin m_busy = 0; m_held = 1; end
            end else if (m_held) m_held = 0;
            else if (m_busy) begin
                if (mc_done_i) m_busy = 0;
                else if (e_kill) begin m_busy = 0; nto = 1; end
                else m_wait++;
            end else if (!jump_flag_i && mc_start_i && !mc_done_i) begin
                m_busy = 1; m_wait = 0;
            end
            if (perf_clr_i) m_cnt = 0;
            else if (e_fl[6] && m_cnt < 2**CW - 1) m_cnt++;
            m_to = nto;
        end
    endtask

    task automatic check_all(input string ph);
        model_outputs();
        chk({ph, ".flags"}, 32'(dut_fl), 32'(e_fl));
        chk({ph, ".jump_flag"}, 32'(jump_flag_o), 32'(e_jf));
        chk({ph, ".jump_addr"}, jump_addr_o, e_jf ? jump_addr_i : 32'h0);
        chk({ph, ".mc_timeout"}, 32'(mc_timeout_o), 32'(m_to));
        chk({ph, ".stall_cnt"}, 32'(stall_cnt_o), 32'(m_cnt));
        o_fl = dut_fl; o_jf = jump_flag_o; o_ja = jump_addr_o; o_to = mc_timeout_o; o_cnt = stall_cnt_o;
    endtask

    task automatic cyc(input bit lu, input bit jf, input logic [31:0] ja, input bit ms,
                       input bit md, input bit st, input bit clr, input string ph);
        load_use_i = lu; jump_flag_i = jf; jump_addr_i = ja; mem_stall_i = ms;
        mc_done_i = md; mc_start_i = st; perf_clr_i = clr;
        @(negedge clk);
        check_all(ph);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        load_use_i = 1; jump_flag_i = 1; jump_addr_i = 32'hDEAD_BEEF;
        mc_start_i = 1; mc_done_i = 0; mem_stall_i = 0; perf_clr_i = 0;
        model_reset();
        #2;
        check_all("reset");
        chk("reset.flags_zero", 32'(o_fl), 32'h0);
        #10;
        load_use_i = 0; jump_flag_i = 0; jump_addr_i = 0; mc_start_i = 0;
        rst_n = 1'b1;
        @(posedge clk); model_advance(); #1;

        // T1 load-use bubble
        cyc(1, 0, 0, 0, 0, 0, 0, "t1");
        chk("t1.luflags", 32'(o_fl), 32'b1100100);
        cyc(0, 0, 0, 0, 0, 0, 0, "t1b");
        chk("t1.after_flags", 32'(o_fl), 32'h0);
        chk("t1.cnt", 32'(o_cnt), 32'd1);

        // T2 redirect overrides load-use
        cyc(1, 1, 32'h100, 0, 0, 0, 0, "t2");
        chk("t2.jf", 32'(o_jf), 32'd1);
        chk("t2.ja", o_ja, 32'h100);
        chk("t2.flags", 32'(o_fl), 32'b0010100);

        // T3 multi-cycle op, done at t0+5
        cyc(0, 0, 0, 0, 0, 0, 1, "t3clr");
        cyc(0, 0, 0, 0, 0, 1, 0, "t3s");
        chk("t3.start_flags", 32'(o_fl), 32'b1101001);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, "t3w");
        chk("t3.wait_flags", 32'(o_fl), 32'b1101001);
        cyc(0, 0, 0, 0, 1, 0, 0, "t3d");
        chk("t3.done_flags", 32'(o_fl), 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, "t3e");
        chk("t3.cnt", 32'(o_cnt), 32'd5);

        // T4 watchdog kill at t0+8
        cyc(0, 0, 0, 0, 0, 1, 0, "t4s");
        repeat (7) cyc(0, 1, 32'h44, 0, 0, 0, 0, "t4w");
        cyc(0, 1, 32'h44, 0, 0, 0, 0, "t4k");
        chk("t4.kill_flags", 32'(o_fl), 32'b1100101);
        chk("t4.kill_jf", 32'(o_jf), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, "t4p");
        chk("t4.timeout", 32'(o_to), 32'd1);
        chk("t4.run_flags", 32'(o_fl), 32'h0);

        // T5 done during bus stall
        cyc(0, 0, 0, 0, 0, 1, 0, "t5s");
        cyc(0, 0, 0, 0, 0, 0, 0, "t5w");
        cyc(0, 0, 0, 1, 1, 0, 0, "t5sd");
        chk("t5.stall_flags", 32'(o_fl), 32'b1101010);
        cyc(0, 0, 0, 1, 0, 0, 0, "t5ss");
        chk("t5.stall2_flags", 32'(o_fl), 32'b1101010);
        cyc(0, 0, 0, 0, 0, 0, 0, "t5r");
        chk("t5.release_flags", 32'(o_fl), 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, "t5run");
        chk("t5.run_lu", 32'(o_fl), 32'b1100100);

        // T6 redirect deferred by bus stall
        repeat (3) begin
            cyc(0, 1, 32'h2000, 1, 0, 0, 0, "t6st");
            chk("t6.jf_stalled", 32'(o_jf), 32'd0);
        end
        cyc(0, 1, 32'h2000, 0, 0, 0, 0, "t6go");
        chk("t6.jf_released", 32'(o_jf), 32'd1);
        chk("t6.ja", o_ja, 32'h2000);

        // Async reset in the middle of MC_WAIT
        cyc(0, 0, 0, 0, 0, 1, 0, "arst_s");
        cyc(0, 0, 0, 0, 0, 0, 0, "arst_w");
        load_use_i = 1; jump_flag_i = 1; jump_addr_i = 32'h55;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("arst");
        chk("arst.flags_zero", 32'(o_fl), 32'h0);
        chk("arst.jf_zero", 32'(o_jf), 32'd0);
        @(posedge clk); #1;
        load_use_i = 0; jump_flag_i = 0; jump_addr_i = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); model_advance(); #1;
        cyc(1, 0, 0, 0, 0, 0, 0, "arst_run");
        chk("arst.run_lu", 32'(o_fl), 32'b1100100);

        // Counter saturation and clear priority
        cyc(0, 0, 0, 0, 0, 0, 1, "sat_clr");
        repeat (70) cyc(1, 0, 0, 0, 0, 0, 0, "sat");
        cyc(1, 0, 0, 0, 0, 0, 1, "sat_last");
        chk("sat.cnt", 32'(o_cnt), 32'd63);
        cyc(0, 0, 0, 0, 0, 0, 0, "sat_after");
        chk("sat.cleared", 32'(o_cnt), 32'd0);

        // Random traffic
        repeat (3000) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom(),
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, "rnd");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
